// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states and
// an index-width helper.
package nibble_serial_adder_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle for nibble_serial_adder; master issues operands,
// slave (the adder) returns status and result.
interface nibble_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c;
    c3   = c[3];
  end
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that feeds one operand nibble per cycle (LSB first) through a
// single 4-bit lookahead slice, chaining the carry through a register.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst,
  nibble_serial_adder_if.slave  bus
);
  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = (clog2(NIB) < 1) ? 1 : clog2(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [NIB_W-1:0]   a_nib, b_nib, slice_sum;
  logic               slice_cout, slice_c3;
  logic [WIDTH-1:0]   acc_wr;

  cla4_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  // Constant-index decode keeps the nibble mux and the result write-back free of variable part-selects.
  always_comb begin
    a_nib  = '0;
    b_nib  = '0;
    acc_wr = acc_q;
    for (int unsigned n = 0; n < NIB; n++) begin
      if (idx_q == IDX_W'(n)) begin
        a_nib                      = a_q[n*NIB_W +: NIB_W];
        b_nib                      = b_q[n*NIB_W +: NIB_W];
        acc_wr[n*NIB_W +: NIB_W]   = slice_sum;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d   = acc_wr;
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          idx_d   = '0;
          sum_d   = acc_wr;
          cout_d  = slice_cout;
          ovf_d   = slice_c3 ^ slice_cout;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): vector table,
// random operations and hand-written multi-cycle corner cases.
module tb_nibble_serial_adder;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  res_t sb_q[$];
  logic [WIDTH-1:0] prev_sum;
  vec_t vecs[5];

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus_if ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    res_t r;
    logic [WIDTH:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  // Issues one op; returns in the sample where done is high. inj >= 0 pulses a
  // junk start at that busy cycle.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input int inj);
    int   cycles;
    res_t e;
    bus_if.start = 1'b1;
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.cin   = cin;
    sb_q.push_back(model(a, b, cin));
    tick();
    bus_if.start = 1'b0;
    bus_if.a     = ~a;
    bus_if.b     = ~b;
    bus_if.cin   = ~cin;
    check("sum_held_in_run", {16'h0, bus_if.sum}, {16'h0, prev_sum});
    cycles = 0;
    while (bus_if.busy === 1'b1 && cycles < 20) begin
      cycles++;
      if (cycles - 1 == inj) begin
        bus_if.start = 1'b1;
        bus_if.a     = 16'hAAAA;
      end else begin
        bus_if.start = 1'b0;
      end
      tick();
    end
    bus_if.start = 1'b0;
    check("busy_cycles", cycles, NIB);
    check("done_pulse", {31'h0, bus_if.done}, 32'h1);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      check("sum",      {16'h0, bus_if.sum},      {16'h0, e.sum});
      check("cout",     {31'h0, bus_if.cout},     {31'h0, e.cout});
      check("overflow", {31'h0, bus_if.overflow}, {31'h0, e.ovf});
      prev_sum = e.sum;
    end
  endtask

  task automatic finish_op();
    tick();
    check("done_one_cycle", {31'h0, bus_if.done}, 32'h0);
    check("idle_after_done", {31'h0, bus_if.busy}, 32'h0);
  endtask

  initial begin
    int saw_done;
    n_cmp    = 0;
    n_err    = 0;
    prev_sum = '0;
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    bus_if.cin   = 1'b0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 1'b0};

    tick();
    tick();
    check("rst_busy", {31'h0, bus_if.busy}, 32'h0);
    check("rst_done", {31'h0, bus_if.done}, 32'h0);
    check("rst_sum",  {16'h0, bus_if.sum},  32'h0);
    check("rst_cout", {31'h0, bus_if.cout}, 32'h0);
    check("rst_ovf",  {31'h0, bus_if.overflow}, 32'h0);
    rst = 1'b0;
    tick();

    // Table vectors: the expected columns are hand-derived constants.
    for (int i = 0; i < 5; i++) begin
      res_t m;
      m = model(vecs[i].a, vecs[i].b, vecs[i].cin);
      check("table_model", {15'h0, m.cout, m.sum, m.ovf},
            {15'h0, vecs[i].exp_cout, vecs[i].exp_sum, vecs[i].exp_ovf});
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, -1);
      finish_op();
    end

    for (int i = 0; i < 6; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), -1);
      finish_op();
    end

    // Start during RUN cycle 2 is ignored.
    run_op(16'h0001, 16'h0001, 1'b0, 1);
    // Back-to-back: start asserted in the DONE cycle.
    run_op(16'h0100, 16'h0200, 1'b0, -1);
    finish_op();

    // Reset during RUN cycle 3 aborts without a done pulse.
    bus_if.start = 1'b1;
    bus_if.a     = 16'h8000;
    bus_if.b     = 16'h8000;
    bus_if.cin   = 1'b0;
    tick();
    bus_if.start = 1'b0;
    tick();
    tick();
    check("run3_busy", {31'h0, bus_if.busy}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'h0, bus_if.busy}, 32'h0);
    check("abort_done", {31'h0, bus_if.done}, 32'h0);
    check("abort_sum",  {16'h0, bus_if.sum},  32'h0);
    check("abort_cout", {31'h0, bus_if.cout}, 32'h0);
    check("abort_ovf",  {31'h0, bus_if.overflow}, 32'h0);
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus_if.done === 1'b1) saw_done++;
    end
    check("no_done_after_abort", saw_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
